// File: rtl/risc_v_mike_div.sv
// risc_v_mike_div: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// It is the multi-cycle partner of the combinational ALU. A start/busy/done
// handshake lets the control unit stall the pipeline until the result is ready.
// Build option RISC_V_MIKE_DIV_FAST_SPECIAL_EN: when defined, divide-by-zero and
// signed overflow finish directly from IDLE, so done arrives one cycle after start.
// When undefined, those cases run the full loop. Result values are the same either way.
module risc_v_mike_div #(
    parameter int DATA_32_W = 32,
    parameter int DATA_W    = DATA_32_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              div_start,
    input  logic [1:0]        div_op,
    input  logic [DATA_W-1:0] div_src_a,
    input  logic [DATA_W-1:0] div_src_b,
    input  logic              div_flush,
    output logic              div_busy,
    output logic              div_done,
    output logic [DATA_W-1:0] div_result
);

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(1);
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]  counter;
    logic [1:0]        op_reg;
    logic [DATA_W-1:0] dividend_reg;
    logic [DATA_W-1:0] divisor_mag;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W:0]   part_rem;
    logic              neg_quot;
    logic              neg_rem;
    logic              zero_reg;
    logic              ovf_reg;

    logic              accept;
    logic              in_signed;
    logic              in_zero;
    logic              in_ovf;
    logic              in_special;
    logic [DATA_W-1:0] in_mag_a;
    logic [DATA_W-1:0] in_mag_b;

    logic [DATA_W+1:0] shifted;
    logic [DATA_W+1:0] trial;
    logic [DATA_W-1:0] quot_step;
    logic [DATA_W:0]   rem_step;

    logic [DATA_W-1:0] finish_value;
    logic [DATA_W-1:0] result_next;
    logic              load_result;

    // Corner-case results: all ones / dividend for divide-by-zero, dividend / zero for overflow
    function automatic logic [DATA_W-1:0] special_value(input logic [1:0]        op,
                                                        input logic [DATA_W-1:0] dividend,
                                                        input logic              by_zero);
        logic [DATA_W-1:0] value;
        if (by_zero) begin
            value = op[1] ? dividend : '1;
        end else begin
            value = op[1] ? '0 : dividend;
        end
        return value;
    endfunction

    // Applies the sign fix-up to the unsigned quotient or remainder
    function automatic logic [DATA_W-1:0] normal_value(input logic [1:0]        op,
                                                       input logic [DATA_W-1:0] quot,
                                                       input logic [DATA_W-1:0] rem,
                                                       input logic              neg_q,
                                                       input logic              neg_r);
        logic [DATA_W-1:0] value;
        if (op[1]) begin
            value = neg_r ? -rem : rem;
        end else begin
            value = neg_q ? -quot : quot;
        end
        return value;
    endfunction

    // Decode the incoming request: acceptance, magnitudes and special-case detection
    always_comb begin
        accept    = div_start && !div_flush && (state != CALC);
        in_signed = !div_op[0];
        in_zero   = (div_src_b == '0);
        in_ovf    = in_signed && (div_src_a == MOST_NEG) && (div_src_b == '1);
        in_mag_a  = (in_signed && div_src_a[DATA_W-1]) ? -div_src_a : div_src_a;
        in_mag_b  = (in_signed && div_src_b[DATA_W-1]) ? -div_src_b : div_src_b;
`ifdef RISC_V_MIKE_DIV_FAST_SPECIAL_EN
        in_special = in_zero || in_ovf;
`else
        in_special = 1'b0;
`endif
    end

    // One restoring step: shift in the next dividend bit and subtract the divisor if it fits
    always_comb begin
        shifted = {part_rem, quotient[DATA_W-1]};
        trial   = shifted - {2'b00, divisor_mag};
        if (trial[DATA_W+1]) begin
            rem_step  = shifted[DATA_W:0];
            quot_step = {quotient[DATA_W-2:0], 1'b0};
        end else begin
            rem_step  = trial[DATA_W:0];
            quot_step = {quotient[DATA_W-2:0], 1'b1};
        end
    end

    // Select the value written into div_result on the edge that enters DONE
    always_comb begin
        if (zero_reg || ovf_reg) begin
            finish_value = special_value(op_reg, dividend_reg, zero_reg);
        end else begin
            finish_value = normal_value(op_reg, quot_step, rem_step[DATA_W-1:0],
                                        neg_quot, neg_rem);
        end
        result_next = (state == CALC) ? finish_value
                                      : special_value(div_op, div_src_a, in_zero);
        load_result = (state_next == DONE);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush wins over everything, including a new start
    always_comb begin
        state_next = state;
        if (div_flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (div_start) begin
                        state_next = in_special ? DONE : CALC;
                    end
                end
                CALC: begin
                    if (counter == CNT_LAST) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    if (div_start) begin
                        state_next = in_special ? DONE : CALC;
                    end else begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from the state
    always_comb begin
        div_busy = 1'b0;
        div_done = 1'b0;
        if (state == CALC) begin
            div_busy = 1'b1;
        end
        if (state == DONE) begin
            div_done = 1'b1;
        end
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter      <= '0;
            op_reg       <= '0;
            dividend_reg <= '0;
            divisor_mag  <= '0;
            quotient     <= '0;
            part_rem     <= '0;
            neg_quot     <= 1'b0;
            neg_rem      <= 1'b0;
            zero_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
            div_result   <= '0;
        end else begin
            if (accept) begin
                counter      <= CNT_LOAD;
                op_reg       <= div_op;
                dividend_reg <= div_src_a;
                divisor_mag  <= in_mag_b;
                quotient     <= in_mag_a;
                part_rem     <= '0;
                neg_quot     <= in_signed && (div_src_a[DATA_W-1] ^ div_src_b[DATA_W-1]);
                neg_rem      <= in_signed && div_src_a[DATA_W-1];
                zero_reg     <= in_zero;
                ovf_reg      <= in_ovf;
            end else if (state == CALC) begin
                counter  <= counter - CNT_LAST;
                quotient <= quot_step;
                part_rem <= rem_step;
            end
            if (load_result) begin
                div_result <= result_next;
            end
        end
    end

endmodule

// File: tb/tb_risc_v_mike_div.sv
// tb_risc_v_mike_div: directed and randomized checks of risc_v_mike_div against a
// behavioural model built on plain 64-bit integer division.
module tb_risc_v_mike_div;

    localparam int NORMAL_LAT = 33;
`ifdef RISC_V_MIKE_DIV_FAST_SPECIAL_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif

    logic        clk;
    logic        rst_n;
    logic        div_start;
    logic [1:0]  div_op;
    logic [31:0] div_src_a;
    logic [31:0] div_src_b;
    logic        div_flush;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_result;

    int          checks;
    int          errors;
    logic [31:0] last_result;

    risc_v_mike_div #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_start  (div_start),
        .div_op     (div_op),
        .div_src_a  (div_src_a),
        .div_src_b  (div_src_b),
        .div_flush  (div_flush),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .div_result (div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32M semantics from 64-bit arithmetic; SV division truncates toward zero
    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        if (b == 32'h0) begin
            r = op[1] ? ua : 64'h0000_0000_FFFF_FFFF;
        end else begin
            case (op)
                2'd0:    r = sa / sb;
                2'd1:    r = ua / ub;
                2'd2:    r = sa % sb;
                default: r = ua % ub;
            endcase
        end
        return 32'(r);
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        div_start = 1'b1;
        div_op    = op;
        div_src_a = a;
        div_src_b = b;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        checkOutput("idle_busy", {31'b0, div_busy}, 32'd0);
        checkOutput("idle_done", {31'b0, div_done}, 32'd0);
        checkOutput("idle_result", div_result, last_result);
    endtask

    // Starts an operation at the current negedge and checks every cycle up to done.
    // inj_cyc optionally injects a stray start (ignored) or a flush in that cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input int inj_cyc = 0, input bit inj_flush = 1'b0);
        logic [31:0] expected;
        int          lat;
        int          end_cyc;
        logic        exp_busy;
        logic        exp_done;
        expected = ref_model(op, a, b);
        lat      = is_special(op, a, b) ? SPECIAL_LAT : NORMAL_LAT;
        end_cyc  = inj_flush ? inj_cyc + 1 : lat;
        applyStimulus(op, a, b);
        for (int cyc = 1; cyc <= end_cyc; cyc++) begin
            @(negedge clk);
            if (inj_flush && cyc > inj_cyc) begin
                exp_busy = 1'b0;
                exp_done = 1'b0;
            end else begin
                exp_busy = (cyc < lat);
                exp_done = (cyc == lat);
            end
            checkOutput({tag, "_busy"}, {31'b0, div_busy}, {31'b0, exp_busy});
            checkOutput({tag, "_done"}, {31'b0, div_done}, {31'b0, exp_done});
            checkOutput({tag, "_result"}, div_result, exp_done ? expected : last_result);
            div_start = 1'b0;
            div_flush = 1'b0;
            if (cyc == inj_cyc) begin
                if (inj_flush) div_flush = 1'b1;
                else applyStimulus(2'b01, 32'd9, 32'd3);
            end
        end
        if (!inj_flush) last_result = expected;
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        checks      = 0;
        errors      = 0;
        last_result = 32'h0;
        rst_n       = 1'b0;
        div_start   = 1'b0;
        div_op      = 2'b00;
        div_src_a   = 32'h0;
        div_src_b   = 32'h0;
        div_flush   = 1'b0;

        // Reset values
        #12;
        checkOutput("reset_busy", {31'b0, div_busy}, 32'd0);
        checkOutput("reset_done", {31'b0, div_done}, 32'd0);
        checkOutput("reset_result", div_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed values
        run_op(2'b00, 32'd100, 32'd7, "div_100_7");
        idle_cycle();
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        idle_cycle();
        run_op(2'b01, 32'hFFFF_FFF9, 32'd2, "divu_big_2");
        idle_cycle();
        run_op(2'b00, 32'd5, 32'd0, "div_by_zero");
        idle_cycle();
        run_op(2'b11, 32'd5, 32'd0, "remu_by_zero");
        idle_cycle();
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        idle_cycle();
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        idle_cycle();

        // Stray start while busy, then flush and restart
        run_op(2'b01, 32'd1000, 32'd3, "stall", 5, 1'b0);
        idle_cycle();
        run_op(2'b01, 32'd1000, 32'd3, "flush", 10, 1'b1);
        run_op(2'b01, 32'd1000, 32'd7, "after_flush");
        idle_cycle();

        // Asynchronous reset mid-operation
        applyStimulus(2'b00, 32'd123456, 32'd13);
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge clk);
            div_start = 1'b0;
            checkOutput("pre_reset_busy", {31'b0, div_busy}, 32'd1);
        end
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_busy", {31'b0, div_busy}, 32'd0);
        checkOutput("async_reset_done", {31'b0, div_done}, 32'd0);
        checkOutput("async_reset_result", div_result, 32'd0);
        last_result = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b00, 32'd42, 32'd6, "div_42_6");

        // Back-to-back: next start issued in the DONE cycle
        run_op(2'b11, 32'd100, 32'd7, "b2b_first");
        run_op(2'b00, 32'hFFFF_FF9C, 32'd7, "b2b_second");
        idle_cycle();

        // Randomized operations with forced corner cases mixed in
        for (int n = 0; n < 24; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case (n % 6)
                0: rb = 32'h0;
                1: begin
                    ra = 32'h8000_0000;
                    rb = 32'hFFFF_FFFF;
                end
                2: rb = (rb >> 20) | 32'd1;
                4: rb = (rb >> 28) | 32'd1;
                default: ;
            endcase
            if (n % 6 != 3) idle_cycle();
            run_op(rop, ra, rb, "rand");
        end
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/risc_v_mike_div.md
# risc_v_mike_div

Iterative radix-2 integer divider implementing RV32M DIV, DIVU, REM and REMU for the risc_v_mike core. It sits beside the single-cycle ALU in the execute stage. The ALU is combinational; this block is its multi-cycle counterpart. The control unit hands it operands through a start/busy/done handshake and stalls the pipeline until the result returns.

## Interface
- DATA_W, default DATA_32_W (32): operand and result width.
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- div_start  input  1  request pulse; sampled only when div_busy=0.
- div_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; captured with div_start.
- div_src_a  input  DATA_W  dividend; captured with div_start.
- div_src_b  input  DATA_W  divisor; captured with div_start.
- div_flush  input  1  synchronous abort of the operation in flight.
- div_busy  output  1  high while an operation is in flight.
- div_done  output  1  one-cycle pulse when div_result becomes valid.
- div_result  output  DATA_W  registered quotient or remainder; held until the next div_done.

## Operation
- State machine:
  - IDLE: div_start=1 captures the operands. Normal operands go to CALC, with the iteration counter loaded to DATA_W. Special cases go to DONE (see Configuration).
  - CALC: produces one quotient bit per cycle by restoring shift/subtract of a (DATA_W+1)-bit partial remainder. The counter decrements each cycle; at counter=1 the next state is DONE.
  - DONE: div_done=1 and div_result is loaded. The next state is IDLE, or CALC/DONE if a new div_start arrives in this cycle.
- div_busy=1 in CALC only; it is 0 in IDLE and DONE.
- Signed ops (DIV, REM):
  - Magnitudes are taken at capture.
  - The quotient is negated when operand signs differ.
  - The remainder takes the sign of the dividend.
- Unsigned ops (DIVU, REMU) use the operands as-is.
- Divide by zero:
  - quotient = all ones (DIV and DIVU);
  - remainder = dividend (REM and REMU).
- Signed overflow (dividend = most negative, divisor = -1):
  - quotient = dividend;
  - remainder = 0.
- div_start while div_busy=1 is ignored; the operation in flight is unaffected.
- div_flush=1 in any state forces IDLE on the next edge with no div_done.
  - div_flush has priority over div_start in the same cycle.
  - div_result keeps its previous value.

## Timing
- Reset values:
  - state IDLE;
  - div_busy 0;
  - div_done 0;
  - div_result 0;
  - counter 0.
- Normal latency: div_start sampled at edge 0 → CALC during cycles 1..DATA_W → div_done high in cycle DATA_W+1 (cycle 33 for DATA_W=32).
- Special-case latency: div_done is high in cycle 1 when the fast path is compiled in (see Configuration).
- Back-to-back operation: div_start in the DONE cycle is accepted. The second operation's div_done follows DATA_W+1 cycles later.
- div_result changes only on the edge that enters DONE. It is stable in every other cycle.
- Reset asserted mid-operation clears immediately, asynchronously, to the reset values.

## Configuration
- Macro: RISC_V_MIKE_DIV_FAST_SPECIAL_EN.
- Defined: divide-by-zero and signed overflow are detected at capture and go IDLE→DONE, so div_done arrives in cycle 1.
- Undefined: all operations run the full DATA_W CALC cycles, and the special-case results are applied in DONE. Result values are identical in both builds; only latency differs.

## Test plan
- DIV 100 / 7 → div_result 14 (0x0000000E), div_done in cycle 33 only, div_busy high cycles 1..32.
- REM 0xFFFFFFF9 (-7) by 2 → 0xFFFFFFFF (-1); DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- DIV 5 / 0 → 0xFFFFFFFF; REMU 5 % 0 → 5; div_done in cycle 1 with the macro defined, cycle 33 without.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM on the same operands → 0.
- Stall and flush:
  - During a DIVU 1000/3, pulse div_start with 9/3 in cycle 5 → ignored; result is 333 in cycle 33.
  - Repeat with div_flush in cycle 10 → no div_done, div_busy 0 from cycle 11; a new start in cycle 11 completes correctly.
- Reset and back-to-back:
  - Assert rst_n=0 in cycle 15 of an operation → div_busy, div_done and div_result are 0 immediately; a subsequent DIV 42/6 → 7.
  - Issue a new start in the DONE cycle → the second result arrives 33 cycles later.
